subtrator_serial_ctrl: RTL and testbench

Multi-cycle N-bit subtractor controller. It computes A - B - bin two bits per clock by sequencing a single 2-bit borrow-ripple subtractor slice, and carries the borrow between slices in a register. It sits between the operand registers and downstream logic, and trades latency for area against a full-width ripple subtractor. It uses a start/done handshake and holds the result stably between operations.

---
 rtl/subtrator_serial_ctrl.sv | 156 +++++++++++++++
 tb/tb_subtrator_serial_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_ctrl.sv
// subtrator_serial_ctrl
// Multi-cycle WIDTH-bit subtractor: computes a - b - bin two bits per clock
// by stepping one 2-bit borrow-ripple slice across the captured operands.
// The borrow is carried between steps in a register. Results are registered
// and held until the next operation completes.
module subtrator_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject odd or too-small widths at elaboration time.
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("subtrator_serial_ctrl: WIDTH must be even and >= 2");
    end

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             brw_q,    brw_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             bout_q,   bout_d;
    logic             zero_q,   zero_d;

    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic [2:0]       slice_diff;
    logic             slice_borrow;
    logic [WIDTH-1:0] acc_wr;

    // Select the operand bit-pair addressed by the step counter.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            if (cnt_q == CW'(k)) begin
                slice_a = a_q[2*k +: 2];
                slice_b = b_q[2*k +: 2];
            end
        end
    end

    // 2-bit borrow-ripple slice; bit 2 of the 3-bit difference is the borrow.
    always_comb begin
        slice_diff   = {1'b0, slice_a} - {1'b0, slice_b} - {2'b00, brw_q};
        slice_borrow = slice_diff[2];
    end

    // Accumulator image with the current slice difference merged in.
    always_comb begin
        acc_wr = acc_q;
        for (int unsigned k = 0; k < STEPS; k++) begin
            if (cnt_q == CW'(k)) begin
                acc_wr[2*k +: 2] = slice_diff[1:0];
            end
        end
    end

    // Sequencer: accept in IDLE, step STEPS slices in RUN, pulse in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        brw_d    = brw_q;
        result_d = result_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_wr;
                brw_d = slice_borrow;
                if (cnt_q == LAST_STEP) begin
                    // Outputs take the merged image directly so they land on
                    // the same edge as the final slice write.
                    state_d  = S_DONE;
                    result_d = acc_wr;
                    bout_d   = slice_borrow;
                    zero_d   = (acc_wr == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            brw_q    <= 1'b0;
            result_q <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            brw_q    <= brw_d;
            result_q <= result_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
        end
    end

    assign result     = result_q;
    assign borrow_out = bout_q;
    assign zero       = zero_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Directed bench for subtrator_serial_ctrl at WIDTH=8, WIDTH=2 and WIDTH=16.
module tb_subtrator_serial_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start8, bin8, bout8, zero8, busy8, done8;
    logic [7:0] a8, b8, res8;
    logic       start2, bin2, bout2, zero2, busy2, done2;
    logic [1:0] a2, b2, res2;
    logic        start16, bin16, bout16, zero16, busy16, done16;
    logic [15:0] a16, b16, res16;

    int checks = 0;
    int errors = 0;

    subtrator_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .result(res8), .borrow_out(bout8), .zero(zero8), .busy(busy8), .done(done8)
    );

    subtrator_serial_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .result(res2), .borrow_out(bout2), .zero(zero2), .busy(busy2), .done(done2)
    );

    subtrator_serial_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .result(res16), .borrow_out(bout16), .zero(zero16), .busy(busy16), .done(done16)
    );

    // Launch one WIDTH=8 op from an IDLE cycle; lat is the cycle index (1 = cycle
    // after acceptance) at which done is seen, -1 on timeout. Returns one cycle
    // after done (IDLE) with dn_after holding done in that cycle.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output int lat, output logic dn_after);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done8 !== 1'b1) lat = -1;
        @(posedge clk); #1;
        dn_after = done8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
        start2 = 0; a2 = '0; b2 = '0; bin2 = 0;
        start16 = 0; a16 = '0; b16 = '0; bin16 = 0;
        #12;
        checks++;
        if ({res8, bout8, zero8, busy8, done8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: got %h expected 000", {res8, bout8, zero8, busy8, done8});
        end
        checks++;
        if ({res16, bout16, zero16, busy16, done16, res2, bout2, zero2, busy2, done2} !== 26'h0) begin
            errors++;
            $display("FAIL reset2_16: got %h expected 0",
                     {res16, bout16, zero16, busy16, done16, res2, bout2, zero2, busy2, done2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic dn;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        // busy must stay high for the 5 cycles following acceptance
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got %b expected 1", i, busy8);
            end
            checks++;
            if (done8 !== (i == 5)) begin
                errors++;
                $display("FAIL basic_done[%0d]: got %b expected %b", i, done8, (i == 5));
            end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if ({res8, bout8, zero8} !== {8'h1E, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got %h/%b/%b expected 1e/0/0", res8, bout8, zero8);
        end
        @(posedge clk); #1;
        dn = done8;
        checks++;
        if ({busy8, dn} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b done=%b expected 0/0", busy8, dn);
        end
        // latency via the driver for a second identical op
        op8(8'h5A, 8'h3C, 1'b0, lat, dn);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 5", lat);
        end
    endtask

    task automatic test_arith();
        logic [7:0] va [3] = '{8'h00, 8'h10, 8'h10};
        logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h10};
        logic       vi [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] er [3] = '{8'hFF, 8'h00, 8'hFF};
        logic       eb [3] = '{1'b1, 1'b0, 1'b1};
        logic       ez [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        logic dn;
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], vi[i], lat, dn);
            checks++;
            if ({res8, bout8, zero8} !== {er[i], eb[i], ez[i]}) begin
                errors++;
                $display("FAIL arith[%0d]: got %h/%b/%b expected %h/%b/%b",
                         i, res8, bout8, zero8, er[i], eb[i], ez[i]);
            end
            checks++;
            if (dn !== 1'b0) begin
                errors++;
                $display("FAIL arith_pulse[%0d]: got %b expected 0", i, dn);
            end
        end
    endtask

    task automatic test_hold_start();
        logic [7:0] prev;
        int dones = 0;
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        prev = res8;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            if (c % 6 == 1) a8 = 8'hFF;
            if (c % 6 == 3) a8 = 8'h80;
            checks++;
            if (done8 !== (c % 6 == 4)) begin
                errors++;
                $display("FAIL hold_done[%0d]: got %b expected %b", c, done8, (c % 6 == 4));
            end
            if (done8 === 1'b1) begin
                dones++;
                checks++;
                if ({res8, bout8} !== {8'h7F, 1'b0}) begin
                    errors++;
                    $display("FAIL hold_result[%0d]: got %h/%b expected 7f/0", c, res8, bout8);
                end
            end else begin
                checks++;
                if (res8 !== prev) begin
                    errors++;
                    $display("FAIL hold_stable[%0d]: got %h expected %h", c, res8, prev);
                end
            end
            prev = res8;
        end
        start8 = 1'b0;
        checks++;
        if (dones !== 3) begin
            errors++;
            $display("FAIL hold_count: got %0d expected 3", dones);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic dn;
        op8(8'h5A, 8'h3C, 1'b0, lat, dn);
        checks++;
        if (res8 !== 8'h1E) begin
            errors++;
            $display("FAIL rst_prior: got %h expected 1e", res8);
        end
        a8 = 8'hC3; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res8, bout8, zero8, busy8, done8} !== 12'h000) begin
            errors++;
            $display("FAIL rst_abort: got %h expected 000", {res8, bout8, zero8, busy8, done8});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            errors++;
            $display("FAIL rst_held: got %b expected 00", {busy8, done8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h03, 8'h01, 1'b0, lat, dn);
        checks++;
        if ({res8, bout8, zero8} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_after: got %h/%b/%b expected 02/0/0", res8, bout8, zero8);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL rst_latency: got %0d expected 5", lat);
        end
    endtask

    task automatic test_width2();
        logic [1:0] va [2] = '{2'b01, 2'b11};
        logic [1:0] vb [2] = '{2'b10, 2'b01};
        logic       vi [2] = '{1'b1, 1'b0};
        logic [1:0] er [2] = '{2'b10, 2'b10};
        logic       eb [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            a2 = va[i]; b2 = vb[i]; bin2 = vi[i]; start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            checks++;
            if ({busy2, done2} !== 2'b10) begin
                errors++;
                $display("FAIL w2_run[%0d]: got %b expected 10", i, {busy2, done2});
            end
            @(posedge clk); #1;
            checks++;
            if ({busy2, done2} !== 2'b11) begin
                errors++;
                $display("FAIL w2_done[%0d]: got %b expected 11", i, {busy2, done2});
            end
            checks++;
            if ({res2, bout2, zero2} !== {er[i], eb[i], 1'b0}) begin
                errors++;
                $display("FAIL w2_result[%0d]: got %b/%b/%b expected %b/%b/0",
                         i, res2, bout2, zero2, er[i], eb[i]);
            end
            @(posedge clk); #1;
            checks++;
            if ({busy2, done2} !== 2'b00) begin
                errors++;
                $display("FAIL w2_idle[%0d]: got %b expected 00", i, {busy2, done2});
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] av, bv;
        logic       bi;
        logic [8:0] ex;
        int lat;
        logic dn;
        for (int i = 0; i < 200; i++) begin
            av = 8'($urandom);
            bv = (i % 8 == 0) ? av : 8'($urandom);
            bi = (i % 8 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ex = {1'b0, av} - {1'b0, bv} - {8'h00, bi};
            op8(av, bv, bi, lat, dn);
            checks++;
            if ({res8, bout8, zero8, lat, dn} !== {ex[7:0], ex[8], (ex[7:0] == 8'h00), 32'd5, 1'b0}) begin
                errors++;
                $display("FAIL rand8[%0d]: %h-%h-%b got %h/%b/%b lat %0d post %b expected %h/%b/%b lat 5 post 0",
                         i, av, bv, bi, res8, bout8, zero8, lat, dn, ex[7:0], ex[8], (ex[7:0] == 8'h00));
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] av, bv, prev;
        logic        bi;
        logic [16:0] ex;
        int lat;
        for (int i = 0; i < 200; i++) begin
            av = 16'($urandom);
            bv = (i % 8 == 0) ? av : 16'($urandom);
            bi = (i % 8 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ex = {1'b0, av} - {1'b0, bv} - {16'h0000, bi};
            prev = res16;
            a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            // operand inputs change mid-run and must not matter
            a16 = ~av; b16 = ~bv; bin16 = ~bi;
            lat = 1;
            while (done16 !== 1'b1 && lat < 30) begin
                checks++;
                if (res16 !== prev) begin
                    errors++;
                    $display("FAIL rand16_stable[%0d]: got %h expected %h", i, res16, prev);
                end
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if ({res16, bout16, zero16, lat} !== {ex[15:0], ex[16], (ex[15:0] == 16'h0), 32'd9}) begin
                errors++;
                $display("FAIL rand16[%0d]: %h-%h-%b got %h/%b/%b lat %0d expected %h/%b/%b lat 9",
                         i, av, bv, bi, res16, bout16, zero16, lat, ex[15:0], ex[16], (ex[15:0] == 16'h0));
            end
            @(posedge clk); #1;
            checks++;
            if (done16 !== 1'b0) begin
                errors++;
                $display("FAIL rand16_pulse[%0d]: got %b expected 0", i, done16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_hold_start();
        test_reset_midrun();
        test_width2();
        test_random8();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
